lsu_mc: RTL and testbench

- Parametrised multicycle load/store unit. Replaces the fixed byte-select and extend path in front of the register file with a block that handles byte, half, word and optional doubleword loads and stores.
- Generates byte enables and lane-aligned store data, and detects misalignment.
- Sits between the main FSM controller, which issues start and waits for done, and a memory port with a wait-state handshake.

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_lane.sv | 50 +++++
 rtl/lsu_mc.sv | 114 +++++++++++
 tb/tb_lsu_mc.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and the access legality check for the multicycle load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_t;

  // lo is the low three address bits; wide is set when the datapath is 64 bits.
  function automatic logic access_ok(input logic [2:0] lo, input size_t sz, input logic wide);
    case (sz)
      SZ_B:    access_ok = 1'b1;
      SZ_H:    access_ok = ~lo[0];
      SZ_W:    access_ok = lo[1:0] == 2'b00;
      default: access_ok = wide && lo == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: byte enables, positioned store data and extended load value.
module lsu_lane #(
  parameter int N          = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [$clog2(N/8)-1:0] off,
  input  logic [1:0]             size,
  input  logic                   sext,
  input  logic [N-1:0]           wdata,
  input  logic [N-1:0]           rdata,
  output logic [N/8-1:0]         be,
  output logic [N-1:0]           wlane,
  output logic [N-1:0]           ldata
);
  localparam int NB = N / 8;
  localparam int OW = $clog2(NB);

  logic [OW:0]   nb, base;
  logic [NB-1:0] bmask;
  logic [N-1:0]  dmask, sh;
  logic          sgn;

  assign nb = (OW+1)'(1) << size;

  // Item byte k always lands in lane base+k; only the base differs by endianness.
  generate
    if (BIG_ENDIAN) begin : g_be
      assign base = (OW+1)'(NB) - {1'b0, off} - nb;
    end else begin : g_le
      assign base = {1'b0, off};
    end
    for (genvar i = 0; i < NB; i++) begin : g_byte
      assign bmask[i]        = (OW+1)'(i) < nb;
      assign dmask[8*i +: 8] = {8{bmask[i]}};
    end
  endgenerate

  assign sh = rdata >> {base, 3'b000};

  always_comb begin
    sgn = 1'b0;
    for (int i = 0; i < NB; i++)
      if ((OW+1)'(i) == nb - (OW+1)'(1)) sgn = sh[8*i+7];
  end

  assign be    = bmask << base;
  assign wlane = (wdata & dmask) << {base, 3'b000};
  assign ldata = (sh & dmask) | ({N{sext & sgn}} & ~dmask);

endmodule

// File: rtl/lsu_mc.sv
// Multicycle load/store unit between the controller start/done handshake and a wait-state memory port.
module lsu_mc
  import lsu_pkg::*;
#(
  parameter int N          = 32,
  parameter int A          = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           we,
  input  logic [1:0]     size,
  input  logic           sext,
  input  logic [A-1:0]   addr,
  input  logic [N-1:0]   wdata,
  output logic           busy,
  output logic           done,
  output logic           misalign,
  output logic [N-1:0]   rdata,
  output logic           mem_req,
  output logic           mem_we,
  output logic [A-1:0]   mem_adr,
  output logic [N/8-1:0] mem_be,
  output logic [N-1:0]   mem_wdata,
  input  logic [N-1:0]   mem_rdata,
  input  logic           mem_ready
);
  localparam int NB = N / 8;
  localparam int OW = $clog2(NB);

  state_t        state, nxt;
  logic          we_q, sext_q, fault_arm, ok;
  logic [1:0]    size_q;
  logic [A-1:0]  addr_q;
  logic [N-1:0]  wdata_q, wl_c, ld_c;
  logic [NB-1:0] be_c;

  assign ok = access_ok(addr[2:0], size_t'(size), N == 64);

  lsu_lane #(.N(N), .BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .off   (addr_q[OW-1:0]),
    .size  (size_q),
    .sext  (sext_q),
    .wdata (wdata_q),
    .rdata (mem_rdata),
    .be    (be_c),
    .wlane (wl_c),
    .ldata (ld_c)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= nxt;

  // A fault spends one quiet cycle before done, so it reports with the same latency as a hit.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      we_q      <= 1'b0;
      sext_q    <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata     <= '0;
      fault_arm <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        we_q    <= we;
        sext_q  <= sext;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state == ACCESS && mem_ready && !we_q) rdata <= ld_c;
      fault_arm <= (state == FAULT) ? ~fault_arm : 1'b0;
    end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = ok ? ACCESS : FAULT;
      ACCESS:  if (mem_ready) nxt = RESP;
      RESP:    nxt = IDLE;
      default: if (fault_arm) nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = state != IDLE;
    done      = 1'b0;
    misalign  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state)
      ACCESS: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_adr   = {addr_q[A-1:OW], {OW{1'b0}}};
        mem_be    = be_c;
        mem_wdata = wl_c;
      end
      RESP:  done = 1'b1;
      FAULT: begin
        done     = fault_arm;
        misalign = fault_arm;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mc.sv
// Scoreboard bench for lsu_mc: 32-bit big/little endian and 64-bit big endian instances.
module tb_lsu_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, we, sext, mem_ready;
  logic [1:0]  size, sel;
  logic [31:0] addr;
  logic [63:0] wdata, mem_rdata;
  logic [2:0]  st;
  assign st = {sel == 2'd2, sel == 2'd1, sel == 2'd0} & {3{start}};

  logic        busy0, done0, mis0, req0, mwe0;
  logic        busy1, done1, mis1, req1, mwe1;
  logic        busy2, done2, mis2, req2, mwe2;
  logic [31:0] rd0, adr0, wd0, rd1, adr1, wd1, adr2;
  logic [3:0]  be0, be1;
  logic [7:0]  be2;
  logic [63:0] rd2, wd2;

  lsu_mc #(.N(32), .A(32), .BIG_ENDIAN(1'b1)) u_be32 (
    .clk(clk), .reset(reset), .start(st[0]), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata[31:0]), .busy(busy0), .done(done0), .misalign(mis0),
    .rdata(rd0), .mem_req(req0), .mem_we(mwe0), .mem_adr(adr0), .mem_be(be0),
    .mem_wdata(wd0), .mem_rdata(mem_rdata[31:0]), .mem_ready(mem_ready));

  lsu_mc #(.N(32), .A(32), .BIG_ENDIAN(1'b0)) u_le32 (
    .clk(clk), .reset(reset), .start(st[1]), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata[31:0]), .busy(busy1), .done(done1), .misalign(mis1),
    .rdata(rd1), .mem_req(req1), .mem_we(mwe1), .mem_adr(adr1), .mem_be(be1),
    .mem_wdata(wd1), .mem_rdata(mem_rdata[31:0]), .mem_ready(mem_ready));

  lsu_mc #(.N(64), .A(32), .BIG_ENDIAN(1'b1)) u_be64 (
    .clk(clk), .reset(reset), .start(st[2]), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .busy(busy2), .done(done2), .misalign(mis2),
    .rdata(rd2), .mem_req(req2), .mem_we(mwe2), .mem_adr(adr2), .mem_be(be2),
    .mem_wdata(wd2), .mem_rdata(mem_rdata), .mem_ready(mem_ready));

  // Selected instance's outputs, widened to 64 bits
  logic        v_busy, v_done, v_mis, v_req, v_we;
  logic [31:0] v_adr;
  logic [7:0]  v_be;
  logic [63:0] v_wd, v_rd;
  always_comb begin
    v_busy = busy0; v_done = done0; v_mis = mis0; v_req = req0; v_we = mwe0;
    v_adr = adr0; v_be = {4'h0, be0}; v_wd = {32'h0, wd0}; v_rd = {32'h0, rd0};
    case (sel)
      2'd1: begin
        v_busy = busy1; v_done = done1; v_mis = mis1; v_req = req1; v_we = mwe1;
        v_adr = adr1; v_be = {4'h0, be1}; v_wd = {32'h0, wd1}; v_rd = {32'h0, rd1};
      end
      2'd2: begin
        v_busy = busy2; v_done = done2; v_mis = mis2; v_req = req2; v_we = mwe2;
        v_adr = adr2; v_be = be2; v_wd = wd2; v_rd = rd2;
      end
      default: ;
    endcase
  end

  typedef struct { logic we; logic [31:0] adr; logic [7:0] be; logic [63:0] wd; } mexp_t;
  typedef struct { logic mis; logic [63:0] rd; int lat; int t0; } dexp_t;
  mexp_t mq[$];
  dexp_t dq[$];
  int cyc = 0, stall = 0, n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: holds mem_ready low for `stall` cycles of an active request
  always @(posedge clk) begin
    #2;
    if (v_req && stall > 0) begin
      mem_ready = 1'b0;
      stall--;
    end else mem_ready = v_req;
  end

  // Monitor: memory side checked every request cycle, completion checked on done
  always @(negedge clk) begin
    dexp_t e;
    if (!reset) begin
      chk("busy", 64'(v_busy), 64'(dq.size() != 0));
      if (v_req) begin
        if (mq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL mem_req: got 1, want 0");
        end else begin
          chk("mem_we",    64'(v_we),  64'(mq[0].we));
          chk("mem_adr",   64'(v_adr), 64'(mq[0].adr));
          chk("mem_be",    64'(v_be),  64'(mq[0].be));
          chk("mem_wdata", v_wd,       mq[0].wd);
          if (mem_ready) void'(mq.pop_front());
        end
      end else begin
        chk("idle_be",    64'(v_be), 64'h0);
        chk("idle_wdata", v_wd,      64'h0);
      end
      if (v_done) begin
        if (dq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL done: got 1, want 0");
        end else begin
          e = dq.pop_front();
          chk("misalign", 64'(v_mis), 64'(e.mis));
          chk("rdata",    v_rd,       e.rd);
          chk("latency",  64'(cyc - e.t0), 64'(e.lat));
        end
      end else chk("mis_no_done", 64'(v_mis), 64'h0);
    end
  end

  task automatic issue(input logic [1:0] s, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [63:0] wd, input logic [63:0] mrd,
                       input int stl, input logic acc, input logic [7:0] ebe,
                       input logic [63:0] ewd, input logic [63:0] erd, input logic emis,
                       input int lat);
    @(negedge clk); #1;
    sel = s; we = w; size = sz; sext = sx; addr = a; wdata = wd; mem_rdata = mrd; stall = stl;
    if (acc) mq.push_back('{w, a & ~((s == 2'd2) ? 32'h7 : 32'h3), ebe, ewd});
    dq.push_back('{emis, erd, lat, cyc});
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 30 && dq.size() != 0; i++) @(negedge clk);
    if (dq.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: %0d completions pending, want 0", nm, dq.size());
      dq.delete();
      mq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; we = 1'b0; sext = 1'b0; size = 2'd0; sel = 2'd0;
    addr = '0; wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s); #1;
      chk("rst_busy",  64'(v_busy), 64'h0);
      chk("rst_done",  64'(v_done), 64'h0);
      chk("rst_req",   64'(v_req),  64'h0);
      chk("rst_rdata", v_rd,        64'h0);
      chk("rst_adr",   64'(v_adr),  64'h0);
      chk("rst_be",    64'(v_be),   64'h0);
    end
    sel = 2'd0;
    @(negedge clk); #1 reset = 1'b0;

    // byte loads, big endian 32
    issue(2'd0, 1'b0, 2'd0, 1'b1, 32'h101, 64'h0, 64'h12F45678, 0, 1'b1, 8'h4, 64'h0, 64'hFFFFFFF4, 1'b0, 2);
    wait_done("lb_sext");
    issue(2'd0, 1'b0, 2'd0, 1'b0, 32'h101, 64'h0, 64'h12F45678, 0, 1'b1, 8'h4, 64'h0, 64'h000000F4, 1'b0, 2);
    wait_done("lb_zext");
    // half stores, both endiannesses
    issue(2'd0, 1'b1, 2'd1, 1'b0, 32'h102, 64'hAAAABEEF, 64'h0, 0, 1'b1, 8'h3, 64'h0000BEEF, 64'h000000F4, 1'b0, 2);
    wait_done("sh_be");
    issue(2'd1, 1'b1, 2'd1, 1'b0, 32'h102, 64'hAAAABEEF, 64'h0, 0, 1'b1, 8'hC, 64'hBEEF0000, 64'h0, 1'b0, 2);
    wait_done("sh_le");
    issue(2'd1, 1'b0, 2'd0, 1'b1, 32'h101, 64'h0, 64'h12F45678, 0, 1'b1, 8'h2, 64'h0, 64'h00000056, 1'b0, 2);
    wait_done("lb_le");
    // faults: misaligned word, dword on a 32-bit unit
    issue(2'd0, 1'b0, 2'd2, 1'b0, 32'h103, 64'h0, 64'h55555555, 0, 1'b0, 8'h0, 64'h0, 64'h000000F4, 1'b1, 2);
    wait_done("lw_misalign");
    issue(2'd0, 1'b0, 2'd3, 1'b0, 32'h100, 64'h0, 64'h55555555, 0, 1'b0, 8'h0, 64'h0, 64'h000000F4, 1'b1, 2);
    wait_done("ld_on_32");

    // stalled word load with an ignored start mid-access
    issue(2'd0, 1'b0, 2'd2, 1'b0, 32'h200, 64'h0, 64'hDEADBEEF, 3, 1'b1, 8'hF, 64'h0, 64'hDEADBEEF, 1'b0, 5);
    @(negedge clk);
    @(negedge clk); #1;
    addr = 32'h0; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done("lw_stall");

    // reset in the middle of a stalled access
    issue(2'd0, 1'b0, 2'd2, 1'b0, 32'h0, 64'h0, 64'h11111111, 10, 1'b1, 8'hF, 64'h0, 64'h0, 1'b0, 2);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_req",  64'(v_req),  64'h0);
    chk("rst_mid_busy", 64'(v_busy), 64'h0);
    chk("rst_mid_rd",   v_rd,        64'h0);
    mq.delete();
    dq.delete();
    stall = 0;
    @(negedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    issue(2'd0, 1'b0, 2'd2, 1'b0, 32'h0, 64'h0, 64'hCAFEBABE, 0, 1'b1, 8'hF, 64'h0, 64'hCAFEBABE, 1'b0, 2);
    wait_done("lw_after_rst");

    // 64-bit big endian
    issue(2'd2, 1'b1, 2'd2, 1'b0, 32'h4, 64'h11223344AABBCCDD, 64'h0, 0, 1'b1, 8'h0F, 64'h00000000AABBCCDD, 64'h0, 1'b0, 2);
    wait_done("sw_64");
    issue(2'd2, 1'b0, 2'd3, 1'b0, 32'h8, 64'h0, 64'h0123456789ABCDEF, 0, 1'b1, 8'hFF, 64'h0, 64'h0123456789ABCDEF, 1'b0, 2);
    wait_done("ld_64");
    issue(2'd2, 1'b0, 2'd1, 1'b1, 32'hE, 64'h0, 64'h0123456789ABCDEF, 0, 1'b1, 8'h03, 64'h0, 64'hFFFFFFFFFFFFCDEF, 1'b0, 2);
    wait_done("lh_64");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
